// File: rtl/instr_boot_loader.sv
// Boot-time loader: waits for a start marker, packs serial bytes big-endian into
// 32-bit words, writes them to instruction memory and releases the CPU on the end marker.
module instr_boot_loader #(
  parameter int          DEPTH      = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  input  logic              instr_valid_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              overflow_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         asm_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                cpu_run_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic                overflow_q;
  logic                busy_q;

  logic [31:0]         word_d;
  logic                room_d;

  function automatic logic is_end_word(input logic [31:0] w);
    return (w == END_WORD);
  endfunction

  // Word as it stands once the current byte is appended, and whether memory has space left.
  always_comb begin
    word_d = {asm_q, instr_i};
    room_d = (word_cnt_q < DEPTH_C);
  end

  // Loader sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_run_q    <= 1'b0;
      word_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cpu_run_q <= 1'b0;
          if (instr_valid_i && (instr_i == START_BYTE)) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (instr_valid_i) begin
            asm_q      <= word_d[23:0];
            byte_idx_q <= byte_idx_q + 2'd1;
            // End marker only counts on a word boundary; a full memory just drops data.
            if (byte_idx_q == 2'd3) begin
              if (is_end_word(word_d)) begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b0;
                cpu_run_q <= 1'b1;
              end else if (room_d) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                imem_wdata_q <= word_d;
                word_cnt_q   <= word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          cpu_run_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          cpu_run_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_run_o    = cpu_run_q;
  assign word_cnt_o   = word_cnt_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_instr_boot_loader.sv
// Bench for instr_boot_loader: a 64-deep and a 4-deep instance share one stimulus stream;
// a byte-queue model predicts every output each cycle, plus literal spot checks.
module tb_instr_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       vld = 1'b0;

  logic        we64, run64, ovf64, busy64;
  logic [5:0]  a64;
  logic [31:0] d64;
  logic [6:0]  c64;
  logic        we4, run4, ovf4, busy4;
  logic [1:0]  a4;
  logic [31:0] d4;
  logic [2:0]  c4;

  instr_boot_loader dut64 (
    .clk_i(clk), .reset(rst), .instr_i(din), .instr_valid_i(vld),
    .imem_we_o(we64), .imem_addr_o(a64), .imem_wdata_o(d64), .cpu_run_o(run64),
    .word_cnt_o(c64), .overflow_o(ovf64), .busy_o(busy64)
  );

  instr_boot_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk_i(clk), .reset(rst), .instr_i(din), .instr_valid_i(vld),
    .imem_we_o(we4), .imem_addr_o(a4), .imem_wdata_o(d4), .cpu_run_o(run4),
    .word_cnt_o(c4), .overflow_o(ovf4), .busy_o(busy4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: phase 0 waiting for start, 1 collecting bytes, 2 running.
  int          ph[2];
  int          nb[2];
  logic [7:0]  bb[2][4];
  int          cnt[2];
  bit          ovf[2];
  bit          e_we[2];
  int          e_addr[2];
  logic [31:0] e_wd[2];
  int          dep[2] = '{64, 4};
  logic [31:0] m_w;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; nb[k] = 0; cnt[k] = 0; ovf[k] = 1'b0;
        e_we[k] = 1'b0; e_addr[k] = 0; e_wd[k] = 32'd0;
      end else begin
        e_we[k] = 1'b0;
        if (vld) begin
          if (ph[k] == 0) begin
            if (din == 8'hFE) begin
              ph[k] = 1;
              nb[k] = 0;
            end
          end else if (ph[k] == 1) begin
            bb[k][nb[k]] = din;
            nb[k]++;
            if (nb[k] == 4) begin
              nb[k] = 0;
              m_w = {bb[k][0], bb[k][1], bb[k][2], bb[k][3]};
              if (m_w == 32'hFFFF_FFFF) ph[k] = 2;
              else if (cnt[k] < dep[k]) begin
                e_we[k] = 1'b1; e_addr[k] = cnt[k]; e_wd[k] = m_w; cnt[k]++;
              end else ovf[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("we64",   32'(we64),   32'(e_we[0]));
    chk("addr64", 32'(a64),    e_addr[0]);
    chk("data64", d64,         e_wd[0]);
    chk("run64",  32'(run64),  32'(ph[0] == 2));
    chk("busy64", 32'(busy64), 32'(ph[0] == 1));
    chk("cnt64",  32'(c64),    cnt[0]);
    chk("ovf64",  32'(ovf64),  32'(ovf[0]));
    chk("we4",    32'(we4),    32'(e_we[1]));
    chk("addr4",  32'(a4),     e_addr[1]);
    chk("data4",  d4,          e_wd[1]);
    chk("run4",   32'(run4),   32'(ph[1] == 2));
    chk("busy4",  32'(busy4),  32'(ph[1] == 1));
    chk("cnt4",   32'(c4),     cnt[1]);
    chk("ovf4",   32'(ovf4),   32'(ovf[1]));
  end

  logic [31:0] la0[$], ld0[$], la1[$], ld1[$];

  always @(negedge clk) begin
    if (we64) begin la0.push_back(32'(a64)); ld0.push_back(d64); end
    if (we4)  begin la1.push_back(32'(a4));  ld1.push_back(d4);  end
  end

  task automatic chk_wr(input string nm, input int k, input int i,
                        input logic [31:0] ea, input logic [31:0] ed);
    int n;
    n = (k == 0) ? la0.size() : la1.size();
    if (n > i) begin
      chk({nm, "_addr"}, (k == 0) ? la0[i] : la1[i], ea);
      chk({nm, "_data"}, (k == 0) ? ld0[i] : ld1[i], ed);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s missing write: actual=%0d writes required>%0d", nm, n, i);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_we"},   32'({we64, we4}),     32'd0);
    chk({nm, "_a"},    32'({a64, a4}),       32'd0);
    chk({nm, "_d"},    d64 | d4,             32'd0);
    chk({nm, "_run"},  32'({run64, run4}),   32'd0);
    chk({nm, "_cnt"},  32'({c64, c4}),       32'd0);
    chk({nm, "_ovf"},  32'({ovf64, ovf4}),   32'd0);
    chk({nm, "_busy"}, 32'({busy64, busy4}), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    din = b; vld = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      din = 8'h00; vld = 1'b0;
    end
  endtask

  task automatic sendw(input logic [31:0] w);
    send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    vld = 1'b0; din = 8'h00;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("por");
    #1 rst = 1'b0;

    // Basic load
    send(8'hFE);
    sendw(32'h0050_0093);
    sendw(32'h0010_0113);
    sendw(32'hFFFF_FFFF);
    chk("run_before_end", 32'(run64), 32'd0);
    idle(1);
    chk("run_after_end", 32'(run64), 32'd1);
    idle(2);
    chk("basic_nwr", 32'(la0.size()), 32'd2);
    chk_wr("basic_w0", 0, 0, 32'd0, 32'h0050_0093);
    chk_wr("basic_w1", 0, 1, 32'd1, 32'h0010_0113);
    chk("basic_cnt", 32'(c64), 32'd2);

    // RUN lockout
    send(8'hFE);
    for (int i = 0; i < 8; i++) send(8'(i * 17));
    idle(3);
    chk("lock_nwr", 32'(la0.size()), 32'd2);
    chk("lock_cnt", 32'(c64), 32'd2);
    chk("lock_run", 32'(run64), 32'd1);

    // Leading junk, gapped word, embedded markers, then overflow on the 4-deep instance
    do_reset();
    send(8'h12); send(8'hFF); send(8'h00);
    idle(2);
    chk("junk_busy", 32'(busy64), 32'd0);
    send(8'hFE);
    send(8'hDE); idle(3); send(8'hAD); idle(3); send(8'hBE); idle(3); send(8'hEF);
    idle(2);
    chk("gap_nwr", 32'(la0.size()), 32'd1);
    chk_wr("gap_w0", 0, 0, 32'd0, 32'hDEAD_BEEF);
    sendw(32'hFFFF_FF00);
    sendw(32'hFE00_0013);
    idle(2);
    chk_wr("emb_w1", 0, 1, 32'd1, 32'hFFFF_FF00);
    chk_wr("emb_w2", 0, 2, 32'd2, 32'hFE00_0013);
    chk("emb_busy", 32'(busy64), 32'd1);
    chk("emb_run", 32'(run64), 32'd0);
    sendw(32'h1111_1111);
    sendw(32'h2222_2222);
    chk("ovf_before", 32'(ovf4), 32'd0);
    idle(1);
    chk("ovf_after", 32'(ovf4), 32'd1);
    sendw(32'h3333_3333);
    sendw(32'hFFFF_FFFF);
    idle(2);
    chk("ovf_nwr4", 32'(la1.size()), 32'd4);
    chk_wr("ovf_w3", 1, 3, 32'd3, 32'h1111_1111);
    chk("ovf_cnt4", 32'(c4), 32'd4);
    chk("ovf_run4", 32'(run4), 32'd1);
    chk("ovf_nwr64", 32'(la0.size()), 32'd6);
    chk_wr("ovf_w5_64", 0, 5, 32'd5, 32'h3333_3333);
    chk("ovf64_clear", 32'(ovf64), 32'd0);

    // Reset mid-word
    do_reset();
    send(8'hFE); send(8'hAA); send(8'hBB);
    idle(1);
    chk("mid_busy", 32'(busy64), 32'd1);
    do_reset();
    send(8'hFE);
    sendw(32'h0000_0013);
    idle(2);
    chk("mid_nwr", 32'(la0.size()), 32'd1);
    chk_wr("mid_w0", 0, 0, 32'd0, 32'h0000_0013);
    chk_wr("mid_w0_4", 1, 0, 32'd0, 32'h0000_0013);

    // Zero-length program
    do_reset();
    send(8'hFE);
    sendw(32'hFFFF_FFFF);
    idle(2);
    chk("zero_run", 32'(run64), 32'd1);
    chk("zero_cnt", 32'(c64), 32'd0);
    chk("zero_nwr", 32'(la0.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
